// File: rtl/axis_bram_sink.sv
// AXI-Stream sink that checks an incrementing-data readback burst from axis_bram,
// applying LFSR-driven backpressure and reporting sticky error status.
module axis_bram_sink #(
  parameter int C_AXIS_BRAM_ADDR_WIDTH = 7,
  parameter int C_AXIS_BRAM_DATA_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  ctrl_start,
  input  logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]     ctrl_length,
  input  logic [C_AXIS_BRAM_DATA_WIDTH-1:0]     ctrl_seed,
  input  logic [3:0]                            ctrl_ready_mask,
  input  logic                                  s_axis_tvalid,
  output logic                                  s_axis_tready,
  input  logic [C_AXIS_BRAM_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [C_AXIS_BRAM_DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic                                  s_axis_tlast,
  output logic                                  stat_busy,
  output logic                                  stat_done,
  output logic                                  stat_error,
  output logic                                  stat_err_data,
  output logic                                  stat_err_strb,
  output logic                                  stat_err_last,
  output logic [C_AXIS_BRAM_ADDR_WIDTH-1:0]     stat_first_err_index,
  output logic [C_AXIS_BRAM_ADDR_WIDTH:0]       stat_beat_count
);

  localparam int AW = C_AXIS_BRAM_ADDR_WIDTH;
  localparam int DW = C_AXIS_BRAM_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [7:0]      r_lfsr;
  logic [AW:0]     r_len;
  logic [DW-1:0]   r_seed;
  logic [3:0]      r_mask;
  logic            r_busy;
  logic            r_done;
  logic            r_err_data;
  logic            r_err_strb;
  logic            r_err_last;
  logic [AW-1:0]   r_first_idx;
  logic [AW:0]     r_count;

  logic            w_ready;
  logic            w_accept;
  logic            w_lfsr_fb;
  logic [AW:0]     w_len_in;
  logic [DW-1:0]   w_exp_data;
  logic            w_is_last;
  logic            w_bad_data;
  logic            w_bad_strb;
  logic            w_bad_last;
  logic            w_have_err;

  // tready depends only on registered state, so no input reaches any output.
  assign w_ready    = r_busy && ((r_lfsr[3:0] & r_mask) == 4'd0);
  assign w_accept   = s_axis_tvalid && w_ready;
  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  // A programmed length of zero stands for a full 2^AW-beat burst.
  assign w_len_in   = (ctrl_length == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, ctrl_length};
  assign w_exp_data = r_seed + DW'(r_count);
  assign w_is_last  = (r_count == (r_len - (AW+1)'(1)));
  assign w_bad_data = (s_axis_tdata != w_exp_data);
  assign w_bad_strb = (s_axis_tstrb != '1);
  assign w_bad_last = (s_axis_tlast != w_is_last);
  assign w_have_err = r_err_data || r_err_strb || r_err_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_lfsr      <= 8'hA5;
      r_len       <= '0;
      r_seed      <= '0;
      r_mask      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_data  <= 1'b0;
      r_err_strb  <= 1'b0;
      r_err_last  <= 1'b0;
      r_first_idx <= '0;
      r_count     <= '0;
    end else begin
      if (r_busy) begin
        r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
      end
      case (r_state)
        S_IDLE, S_DONE: begin
          if (ctrl_start) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_err_data  <= 1'b0;
            r_err_strb  <= 1'b0;
            r_err_last  <= 1'b0;
            r_first_idx <= '0;
            r_count     <= '0;
            r_len       <= w_len_in;
            r_seed      <= ctrl_seed;
            r_mask      <= ctrl_ready_mask;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_err_data <= r_err_data || w_bad_data;
            r_err_strb <= r_err_strb || w_bad_strb;
            r_err_last <= r_err_last || w_bad_last;
            if (!w_have_err && (w_bad_data || w_bad_strb || w_bad_last)) begin
              r_first_idx <= r_count[AW-1:0];
            end
            r_count <= r_count + (AW+1)'(1);
            // An early tlast ends the run just like reaching the programmed length.
            if (w_is_last || s_axis_tlast) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis_tready        = w_ready;
  assign stat_busy            = r_busy;
  assign stat_done            = r_done;
  assign stat_err_data        = r_err_data;
  assign stat_err_strb        = r_err_strb;
  assign stat_err_last        = r_err_last;
  assign stat_error           = r_err_data || r_err_strb || r_err_last;
  assign stat_first_err_index = r_first_idx;
  assign stat_beat_count      = r_count;

endmodule

// File: tb/tb_axis_bram_sink.sv
// Self-checking bench for axis_bram_sink: a burst-level behavioural model is compared
// against the DUT every cycle, plus hand-computed end-of-run expectations.
module tb_axis_bram_sink;

  localparam int AW = 7;
  localparam int DW = 8;
  localparam int SW = DW / 8;
  localparam int DRIVE_LIMIT = 4000;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          ctrl_start;
  logic [AW-1:0] ctrl_length;
  logic [DW-1:0] ctrl_seed;
  logic [3:0]    ctrl_ready_mask;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic [SW-1:0] s_axis_tstrb;
  logic          s_axis_tlast;
  logic          stat_busy;
  logic          stat_done;
  logic          stat_error;
  logic          stat_err_data;
  logic          stat_err_strb;
  logic          stat_err_last;
  logic [AW-1:0] stat_first_err_index;
  logic [AW:0]   stat_beat_count;

  int testsRun = 0;
  int testsFailed = 0;

  logic [DW-1:0] beatData [256];
  logic [SW-1:0] beatStrb [256];
  logic          beatLast [256];

  // Behavioural model state, expressed in beats and run results.
  bit mBusy, mDone, mErrD, mErrS, mErrL;
  int mFirst, mCount, mLen, mSeed, mMask, mLfsr;

  always #5 clk = ~clk;

  axis_bram_sink #(
    .C_AXIS_BRAM_ADDR_WIDTH(AW),
    .C_AXIS_BRAM_DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ctrl_start(ctrl_start),
    .ctrl_length(ctrl_length),
    .ctrl_seed(ctrl_seed),
    .ctrl_ready_mask(ctrl_ready_mask),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tstrb(s_axis_tstrb),
    .s_axis_tlast(s_axis_tlast),
    .stat_busy(stat_busy),
    .stat_done(stat_done),
    .stat_error(stat_error),
    .stat_err_data(stat_err_data),
    .stat_err_strb(stat_err_strb),
    .stat_err_last(stat_err_last),
    .stat_first_err_index(stat_first_err_index),
    .stat_beat_count(stat_beat_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int lfsrNext(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) | fb) & 255;
  endfunction

  task automatic modelReset();
    mBusy = 0; mDone = 0; mErrD = 0; mErrS = 0; mErrL = 0;
    mFirst = 0; mCount = 0; mLen = 0; mSeed = 0; mMask = 0; mLfsr = 8'hA5;
  endtask

  function automatic bit modelReady();
    return mBusy && (((mLfsr & 15) & mMask) == 0);
  endfunction

  // Advance the model by one clock using inputs that are stable until the next rising edge.
  task automatic modelStep();
    int  i;
    bit  bd, bs, bl;
    if (mBusy) begin
      if (s_axis_tvalid && modelReady()) begin
        i  = mCount;
        bd = (int'(s_axis_tdata) != ((mSeed + i) % 256));
        bs = (int'(s_axis_tstrb) != ((1 << SW) - 1));
        bl = (s_axis_tlast != (i == mLen - 1));
        if (!(mErrD || mErrS || mErrL) && (bd || bs || bl)) mFirst = i;
        mErrD = mErrD | bd;
        mErrS = mErrS | bs;
        mErrL = mErrL | bl;
        mCount++;
        if (i == mLen - 1 || s_axis_tlast) begin
          mBusy = 0;
          mDone = 1;
        end
      end
      mLfsr = lfsrNext(mLfsr);
    end else if (ctrl_start) begin
      mBusy = 1; mDone = 0; mErrD = 0; mErrS = 0; mErrL = 0;
      mFirst = 0; mCount = 0;
      mLen  = (ctrl_length == 0) ? (1 << AW) : int'(ctrl_length);
      mSeed = int'(ctrl_seed);
      mMask = int'(ctrl_ready_mask);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) modelReset();
    checkOutput("busy", stat_busy, mBusy);
    checkOutput("done", stat_done, mDone);
    checkOutput("tready", s_axis_tready, modelReady());
    checkOutput("errData", stat_err_data, mErrD);
    checkOutput("errStrb", stat_err_strb, mErrS);
    checkOutput("errLast", stat_err_last, mErrL);
    checkOutput("error", stat_error, mErrD | mErrS | mErrL);
    checkOutput("firstIdx", stat_first_err_index, mFirst);
    checkOutput("count", stat_beat_count, mCount);
    if (reset_n) modelStep();
  end

  task automatic buildBurst(input int seed, input int n, input int lastAt);
    for (int i = 0; i < n; i++) begin
      beatData[i] = DW'(seed + i);
      beatStrb[i] = '1;
      beatLast[i] = (i == lastAt);
    end
  endtask

  // Pulse ctrl_start for one cycle; returns in the first RUN cycle.
  task automatic applyStimulus(input int len, input int seed, input int mask);
    ctrl_length     = AW'(len);
    ctrl_seed       = DW'(seed);
    ctrl_ready_mask = 4'(mask);
    ctrl_start      = 1'b1;
    @(posedge clk); #1;
    ctrl_start      = 1'b0;
  endtask

  task automatic driveBeats(input int n, output int cycles, output bit timedOut);
    int  idx;
    bit  rdy;
    idx = 0;
    cycles = 0;
    while (idx < n && cycles < DRIVE_LIMIT) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = beatData[idx];
      s_axis_tstrb  = beatStrb[idx];
      s_axis_tlast  = beatLast[idx];
      @(negedge clk);
      rdy = s_axis_tready;
      @(posedge clk); #1;
      cycles++;
      if (rdy) idx++;
    end
    timedOut = (idx < n);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic cleanBurst(input string tag);
    int cyc;
    bit to;
    buildBurst(4, 4, 3);
    applyStimulus(4, 4, 0);
    driveBeats(4, cyc, to);
    checkOutput({tag, " timeout"}, to, 0);
    checkOutput({tag, " cycles"}, cyc, 4);
    checkOutput({tag, " done"}, stat_done, 1);
    checkOutput({tag, " busy"}, stat_busy, 0);
    checkOutput({tag, " tready"}, s_axis_tready, 0);
    checkOutput({tag, " count"}, stat_beat_count, 4);
    checkOutput({tag, " error"}, stat_error, 0);
  endtask

  initial begin
    int cyc;
    bit to;
    reset_n = 1'b0;
    ctrl_start = 1'b0;
    ctrl_length = '0;
    ctrl_seed = '0;
    ctrl_ready_mask = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tstrb = '0;
    s_axis_tlast = 1'b0;
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", stat_busy, 0);
    checkOutput("reset done", stat_done, 0);
    checkOutput("reset tready", s_axis_tready, 0);
    checkOutput("reset count", stat_beat_count, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    cleanBurst("clean");

    buildBurst(4, 4, 3);
    beatData[2] = 8'd9;
    applyStimulus(4, 4, 0);
    driveBeats(4, cyc, to);
    checkOutput("data timeout", to, 0);
    checkOutput("data errData", stat_err_data, 1);
    checkOutput("data firstIdx", stat_first_err_index, 2);
    checkOutput("data count", stat_beat_count, 4);
    checkOutput("data errStrb", stat_err_strb, 0);
    checkOutput("data errLast", stat_err_last, 0);

    buildBurst(4, 4, 1);
    applyStimulus(4, 4, 0);
    driveBeats(2, cyc, to);
    checkOutput("early timeout", to, 0);
    checkOutput("early done", stat_done, 1);
    checkOutput("early errLast", stat_err_last, 1);
    checkOutput("early firstIdx", stat_first_err_index, 1);
    checkOutput("early count", stat_beat_count, 2);

    buildBurst(4, 4, -1);
    applyStimulus(4, 4, 0);
    driveBeats(4, cyc, to);
    checkOutput("nolast timeout", to, 0);
    checkOutput("nolast done", stat_done, 1);
    checkOutput("nolast errLast", stat_err_last, 1);
    checkOutput("nolast firstIdx", stat_first_err_index, 3);
    checkOutput("nolast count", stat_beat_count, 4);

    buildBurst(8'h10, 4, 3);
    beatStrb[1] = '0;
    applyStimulus(4, 8'h10, 0);
    driveBeats(4, cyc, to);
    checkOutput("strb timeout", to, 0);
    checkOutput("strb errStrb", stat_err_strb, 1);
    checkOutput("strb errData", stat_err_data, 0);
    checkOutput("strb firstIdx", stat_first_err_index, 1);

    // Fresh reset puts the LFSR at A5, whose low nibble 5 blocks the first RUN cycle.
    doReset();
    @(posedge clk); #1;
    buildBurst(8'h20, 16, 15);
    applyStimulus(16, 8'h20, 4'hF);
    checkOutput("bp first tready", s_axis_tready, 0);
    driveBeats(16, cyc, to);
    checkOutput("bp timeout", to, 0);
    checkOutput("bp slower than 16", (cyc > 16), 1);
    checkOutput("bp count", stat_beat_count, 16);
    checkOutput("bp error", stat_error, 0);
    checkOutput("bp done", stat_done, 1);

    buildBurst(8'hF0, 128, 127);
    applyStimulus(0, 8'hF0, 0);
    fork
      driveBeats(128, cyc, to);
      begin
        repeat (20) @(posedge clk);
        #1;
        ctrl_length = AW'(4);
        ctrl_seed   = '0;
        ctrl_start  = 1'b1;
        @(posedge clk); #1;
        ctrl_start  = 1'b0;
      end
    join
    checkOutput("full timeout", to, 0);
    checkOutput("full cycles", cyc, 128);
    checkOutput("full count", stat_beat_count, 128);
    checkOutput("full error", stat_error, 0);
    checkOutput("full done", stat_done, 1);

    buildBurst(4, 4, 3);
    applyStimulus(4, 4, 0);
    driveBeats(2, cyc, to);
    checkOutput("midrst timeout", to, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst busy", stat_busy, 0);
    checkOutput("midrst tready", s_axis_tready, 0);
    checkOutput("midrst count", stat_beat_count, 0);
    checkOutput("midrst done", stat_done, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    cleanBurst("afterrst");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
